// File: rtl/log2pow2_rr_scheduler.sv
// Round-robin front end sharing one Q4.12 log2 and one pow2 approximator among N_REQ lanes.
// Two-stage stalling pipeline: S1 holds the accepted operand, S2 holds the result and drives rsp_*.
module log2pow2_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_op,
    input  logic [16*N_REQ-1:0]   req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_op,
    output logic [15:0]           rsp_data,
    output logic                  rsp_zero_err,
    output logic [1:0]            inflight
);

    logic [ID_W-1:0] ptr;
    logic            s1_vld;
    logic            s1_op;
    logic [ID_W-1:0] s1_id;
    logic [15:0]     s1_data;

    logic            s2_load;
    logic            s1_adv;
    logic            accept_en;
    logic            accept;
    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic            s1_nxt;
    logic            s2_nxt;

    assign s2_load   = !rsp_valid || rsp_ready;
    assign s1_adv    = s1_vld && s2_load;
    assign accept_en = !rst && (!s1_vld || s2_load);
    assign accept    = accept_en && grant_vld;
    assign s1_nxt    = accept || (s1_vld && !s1_adv);
    assign s2_nxt    = s2_load ? s1_vld : rsp_valid;

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    logic [3:0]  lead;
    logic [11:0] log2_frac;
    logic [15:0] log2_res;
    logic [3:0]  pow2_exp;
    logic [31:0] pow2_mant;
    logic [15:0] pow2_res;
    logic        zero_op;
    logic [15:0] result;

    always_comb begin
        lead = 4'd0;
        for (int b = 0; b < 16; b++) begin
            if (s1_data[b]) begin
                lead = 4'(b);
            end
        end
        // Normalise the leading one to bit 15; the 12 bits beneath it are the fraction.
        log2_frac = 12'((s1_data << (4'd15 - lead)) >> 3);
        log2_res  = {lead - 4'd12, log2_frac};

        pow2_exp  = s1_data[15:12];
        pow2_mant = {19'd0, 1'b1, s1_data[11:0]};
        if (!pow2_exp[3]) begin
            pow2_res = 16'(pow2_mant << pow2_exp[2:0]);
        end else begin
            pow2_res = 16'(pow2_mant >> (4'd0 - pow2_exp));
        end

        zero_op = !s1_op && (s1_data == 16'd0);
        if (zero_op) begin
            result = 16'h8000;
        end else if (s1_op) begin
            result = pow2_res;
        end else begin
            result = log2_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            s1_vld       <= 1'b0;
            s1_op        <= 1'b0;
            s1_id        <= '0;
            s1_data      <= 16'd0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_op       <= 1'b0;
            rsp_data     <= 16'd0;
            rsp_zero_err <= 1'b0;
            inflight     <= 2'd0;
        end else begin
            if (accept) begin
                s1_vld  <= 1'b1;
                s1_op   <= req_op[grant_id];
                s1_id   <= grant_id;
                s1_data <= req_data[16*int'(grant_id) +: 16];
                ptr     <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end

            if (s2_load) begin
                rsp_valid <= s1_vld;
                if (s1_vld) begin
                    rsp_id       <= s1_id;
                    rsp_op       <= s1_op;
                    rsp_data     <= result;
                    rsp_zero_err <= zero_op;
                end
            end

            inflight <= {1'b0, s1_nxt} + {1'b0, s2_nxt};
        end
    end

endmodule
